id_ex_skid_stage: RTL and testbench

Parametrised ID/EX pipeline stage for the 5-stage MIPS core. It carries PC, NUM_OPS operand values, the immediate and the control word from decode to execute. Transfers use a valid/ready handshake with a 2-entry skid buffer, so a registered in_ready still sustains one transfer per cycle. It adds flush (bubble insertion on branch/jump redirect), occupancy reporting and a saturating stall counter.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_payload_reg.sv | 18 +
 rtl/id_ex_skid_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_skid_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: stage states, payload sizing, NOP encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int CTRL_NOP = 0;

  function automatic int payload_width(input int data_w, input int num_ops, input int ctrl_w);
    return 2*data_w + num_ops*data_w + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-load payload register, async active-low reset to zero.
// Latency 1 cycle; no flow control of its own, the owner gates load.
module pipe_payload_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX stage with 2-entry skid buffer; 1-cycle latency, full throughput.
// Backpressure: in_ready is registered and drops only once both entries are held.
module id_ex_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int CTRL_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      clr_cnt,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [CTRL_W-1:0]         in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pc,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [DATA_W-1:0]         out_imm,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int PW = payload_width(DATA_W, NUM_OPS, CTRL_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DATA_W-1:0]         pc;
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic [DATA_W-1:0]         imm;
    logic [CTRL_W-1:0]         ctrl;
  } payload_t;

  payload_t     in_pl, main_d, main_q, skid_q;
  stage_state_e state, state_nxt;
  logic         load_main, load_skid, sel_skid;
  logic         accept, deliver;

  assign in_pl   = '{pc: in_pc, ops: in_ops, imm: in_imm, ctrl: in_ctrl};
  assign main_d  = sel_skid ? skid_q : in_pl;
  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  pipe_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_pl),
    .q     (skid_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  // Flush drops both held entries and any offered transfer; payload regs simply hold.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    sel_skid  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_nxt = HALF;
          end
        end
        HALF: begin
          if (accept && deliver) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (deliver) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            load_main = 1'b1;
            sel_skid  = 1'b1;
            state_nxt = HALF;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           stall_cnt <= '0;
    else if (clr_cnt)                                     stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
  end

  always_comb begin
    case (state)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid = (state != EMPTY);
  assign out_pc    = main_q.pc;
  assign out_ops   = main_q.ops;
  assign out_imm   = main_q.imm;
  assign out_ctrl  = out_valid ? main_q.ctrl : CTRL_W'(CTRL_NOP);

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage (NUM_OPS=3, CNT_W=4): directed table, corner sequences, random vs queue model.
module tb_id_ex_skid_stage;

  localparam int DW = 32;
  localparam int NO = 3;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int CNT_SAT = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush, clr_cnt, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]  in_pc, in_imm, out_pc, out_imm;
  logic [NO*DW-1:0] in_ops, out_ops;
  logic [CW-1:0]  in_ctrl, out_ctrl;
  logic [1:0]     occupancy;
  logic [NW-1:0]  stall_cnt;

  id_ex_skid_stage #(.DATA_W(DW), .NUM_OPS(NO), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ops(in_ops), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ops(out_ops), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]    pc;
    logic [NO*DW-1:0] ops;
    logic [DW-1:0]    imm;
    logic [CW-1:0]    ctrl;
  } pl_t;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        erdy;
    logic [1:0]  eocc;
    logic [31:0] epc;
    logic [15:0] ectrl;
  } vec_t;

  // Reference model: the stage is a FIFO of at most two payloads.
  pl_t q[$];
  pl_t last;
  int  m_cnt;
  bit  m_rdy;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last  = '0;
    m_cnt = 0;
    m_rdy = 1'b1;
  endtask

  task automatic drive(input bit iv, input pl_t p, input bit ordy, input bit fl, input bit clr);
    in_valid  = iv;
    in_pc     = p.pc;
    in_ops    = p.ops;
    in_imm    = p.imm;
    in_ctrl   = p.ctrl;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit  ov, acc, dlv;
    pl_t p;
    p   = '{pc: in_pc, ops: in_ops, imm: in_imm, ctrl: in_ctrl};
    ov  = q.size() > 0;
    acc = in_valid && m_rdy && !flush;
    dlv = ov && out_ready;
    if (clr_cnt) m_cnt = 0;
    else if (ov && !out_ready && m_cnt < CNT_SAT) m_cnt++;
    if (flush) q.delete();
    else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    m_rdy = q.size() < 2;
    if (q.size() > 0) last = q[0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, 128'(out_valid), 128'(q.size() > 0));
    chk({tag, "_ready"}, 128'(in_ready), 128'(m_rdy));
    chk({tag, "_occ"},   128'(occupancy), 128'(q.size()));
    chk({tag, "_stall"}, 128'(stall_cnt), 128'(m_cnt));
    chk({tag, "_pc"},    128'(out_pc), 128'(last.pc));
    chk({tag, "_ops"},   128'(out_ops), 128'(last.ops));
    chk({tag, "_imm"},   128'(out_imm), 128'(last.imm));
    chk({tag, "_ctrl"},  128'(out_ctrl), (q.size() > 0) ? 128'(last.ctrl) : 128'(0));
  endtask

  function automatic pl_t mk(input logic [31:0] pc, input logic [15:0] ctrl);
    mk = '{pc: pc, ops: {3{pc}}, imm: ~pc, ctrl: ctrl};
  endfunction

  function automatic pl_t rnd_pl();
    rnd_pl = '{pc: $urandom, ops: {$urandom, $urandom, $urandom}, imm: $urandom,
               ctrl: CW'($urandom_range(0, 65535))};
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 32'h100, 16'h1,  1, 0,  1, 1, 2'd1, 32'h100, 16'h1};
    tbl[1]  = '{1, 32'h104, 16'h2,  1, 0,  1, 1, 2'd1, 32'h104, 16'h2};
    tbl[2]  = '{1, 32'h108, 16'h3,  1, 0,  1, 1, 2'd1, 32'h108, 16'h3};
    tbl[3]  = '{0, 32'h0,   16'h0,  1, 0,  0, 1, 2'd0, 32'h108, 16'h0};
    tbl[4]  = '{1, 32'h200, 16'h4,  0, 0,  1, 1, 2'd1, 32'h200, 16'h4};
    tbl[5]  = '{1, 32'h204, 16'h5,  0, 0,  1, 0, 2'd2, 32'h200, 16'h4};
    tbl[6]  = '{1, 32'h208, 16'h6,  0, 0,  1, 0, 2'd2, 32'h200, 16'h4};
    tbl[7]  = '{0, 32'h0,   16'h0,  1, 0,  1, 1, 2'd1, 32'h204, 16'h5};
    tbl[8]  = '{0, 32'h0,   16'h0,  1, 0,  0, 1, 2'd0, 32'h204, 16'h0};
    tbl[9]  = '{1, 32'h2f0, 16'h7,  0, 0,  1, 1, 2'd1, 32'h2f0, 16'h7};
    tbl[10] = '{1, 32'h2f4, 16'h8,  0, 0,  1, 0, 2'd2, 32'h2f0, 16'h7};
    tbl[11] = '{1, 32'h300, 16'h9,  0, 1,  0, 1, 2'd0, 32'h2f0, 16'h0};
    tbl[12] = '{0, 32'h0,   16'h0,  1, 0,  0, 1, 2'd0, 32'h2f0, 16'h0};
    tbl[13] = '{1, 32'h310, 16'hA,  0, 0,  1, 1, 2'd1, 32'h310, 16'hA};
    tbl[14] = '{1, 32'h314, 16'hB,  1, 1,  0, 1, 2'd0, 32'h310, 16'h0};
    tbl[15] = '{0, 32'h0,   16'h0,  1, 0,  0, 1, 2'd0, 32'h310, 16'h0};

    reset = 1'b0;
    drive(0, '0, 0, 0, 0);
    model_reset();
    #12;
    reset = 1'b1;

    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_ready", 128'(in_ready), 128'(1));
    chk("reset_occ",   128'(occupancy), 128'(0));
    chk("reset_pc",    128'(out_pc), 128'(0));
    chk("reset_stall", 128'(stall_cnt), 128'(0));

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, mk(tbl[i].pc, tbl[i].ctrl), tbl[i].ordy, tbl[i].fl, 0);
      tick();
      chk($sformatf("row%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("row%0d_ready", i), 128'(in_ready), 128'(tbl[i].erdy));
      chk($sformatf("row%0d_occ", i),   128'(occupancy), 128'(tbl[i].eocc));
      chk($sformatf("row%0d_pc", i),    128'(out_pc), 128'(tbl[i].epc));
      chk($sformatf("row%0d_ctrl", i),  128'(out_ctrl), 128'(tbl[i].ectrl));
    end

    // Operand channel ordering.
    begin
      pl_t p;
      p = '{pc: 32'h400, ops: {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, imm: 32'h5, ctrl: 16'h1};
      drive(1, p, 0, 0, 1);
      tick();
      chk("ops_ch0", 128'(out_ops[31:0]),  128'(32'hAAAA_AAAA));
      chk("ops_ch1", 128'(out_ops[63:32]), 128'(32'hBBBB_BBBB));
      chk("ops_ch2", 128'(out_ops[95:64]), 128'(32'hCCCC_CCCC));
      chk("ops_stall0", 128'(stall_cnt), 128'(0));
    end

    // Stall counter saturation and clear priority; one entry held, consumer stalled.
    drive(0, '0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3)  chk("stall_3",  128'(stall_cnt), 128'(3));
      if (i == 15) chk("stall_15", 128'(stall_cnt), 128'(15));
    end
    chk("stall_sat", 128'(stall_cnt), 128'(15));
    clr_cnt = 1'b1;
    tick();
    chk("stall_clr", 128'(stall_cnt), 128'(0));
    clr_cnt = 1'b0;
    tick();
    chk("stall_after_clr", 128'(stall_cnt), 128'(1));

    // Fill to FULL, then pulse async reset between edges.
    drive(1, mk(32'h500, 16'h3), 0, 0, 0);
    tick();
    chk("pre_rst_occ", 128'(occupancy), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_occ",   128'(occupancy), 128'(0));
    chk("arst_ready", 128'(in_ready), 128'(1));
    chk("arst_pc",    128'(out_pc), 128'(0));
    chk("arst_ops",   128'(out_ops), 128'(0));
    chk("arst_imm",   128'(out_imm), 128'(0));
    chk("arst_ctrl",  128'(out_ctrl), 128'(0));
    chk("arst_stall", 128'(stall_cnt), 128'(0));
    drive(0, '0, 0, 0, 0);
    model_reset();
    #1;
    reset = 1'b1;

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, rnd_pl(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      tick();
      model_check($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
